decoder_nx_reg: RTL and testbench
=================================

DECODER_NX_REG -- requirements
Module: decoder_nx_reg

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- SEL_W, 2: select width in bits.
- OUT_N, 4: number of output lines; legal range 2..2**SEL_W.
- STRETCH, 1: pulse-mode output duration in cycles; legal range 1..255.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, input, 1: single clock; all logic is on the rising edge.
- rst_n, input, 1: reset, synchronous, active-low.
- en, input, 1: decode enable, sampled on accept.
- sel, input, SEL_W: line select, sampled on accept.
- mode, input, 1: 0 = pulse, 1 = latch; sampled on accept.
- in_valid, input, 1: request present.
- in_ready, output, 1: block can accept a request this cycle.
- clr, input, 1: synchronous clear of outputs and error.
- dout, output, OUT_N: registered one-hot (or all-zero) decode.
- out_valid, output, 1: one-cycle strobe marking a dout update from an accept.
- err, output, 1: sticky out-of-range flag.

REQ-003 The block SHALL use one clock and a synchronous, active-low reset, rst_n; there SHALL be no other clock or asynchronous input.

Function
REQ-004 An accept SHALL occur in a cycle where in_valid=1 and in_ready=1; in_valid and the request fields SHALL be ignored in any other cycle.

REQ-005 in_ready SHALL be combinational:
- It SHALL equal ~clr & (busy==0).
- busy SHALL be 1 only while a pulse-mode output is still stretching (stretch counter != 0).

REQ-006 Latency: dout, out_valid and err SHALL update on the clock edge that ends the accept cycle, giving one cycle of latency.

REQ-007 An accept with en=1 and sel<OUT_N SHALL set dout to one-hot: bit sel=1 and all other bits 0.

REQ-008 An accept with en=1 and sel>=OUT_N SHALL:
- set dout to 0;
- set err to 1;
- leave err set until clr or reset.

REQ-009 An accept with en=0 SHALL set dout to 0 and SHALL NOT change err.

REQ-010 Every accept SHALL set out_valid=1 for exactly the following cycle, including en=0 and out-of-range accepts; out_valid SHALL be 0 otherwise.

REQ-011 Latch mode (mode=1 at accept):
- dout SHALL hold its value until the next accept, clr or reset.
- busy SHALL stay 0, so back-to-back accepts every cycle are allowed.

REQ-012 Pulse mode (mode=0 at accept):
- dout SHALL hold the decoded value for exactly STRETCH cycles, then return to 0.
- The stretch counter SHALL load STRETCH on accept and decrement once per cycle.
- dout SHALL clear on the edge at which the counter reaches 0.

REQ-013 Pulse mode busy rule:
- busy SHALL be 1 while the counter is nonzero, blocking accepts.
- With STRETCH=1, a new accept SHALL be allowed in the cycle after the pulse.

REQ-014 A pulse-mode accept resolving to dout=0 (en=0 or out-of-range) SHALL still load the counter and block for STRETCH cycles.

REQ-015 clr=1 SHALL, on the next edge:
- set dout=0, err=0 and the counter to 0;
- leave out_valid=0.

Because in_ready=0 whenever clr=1, clr and accept SHALL never coincide.

REQ-016 A change of mode between accepts SHALL only take effect at the next accept; an in-progress pulse SHALL complete unaffected.

REQ-017 State machine:
- States: IDLE (counter=0) and STRETCHING (counter!=0).
- IDLE -> STRETCHING on a pulse-mode accept.
- STRETCHING -> IDLE when the counter reaches 0, on clr, or on reset.
- Latch-mode accepts SHALL stay in IDLE.

REQ-018 Parameter checks: OUT_N outside 2..2**SEL_W, or STRETCH outside 1..255, SHALL be rejected at elaboration.

Reset
REQ-019 While rst_n=0 at a clock edge, the block SHALL set:
- dout=0, out_valid=0, err=0;
- counter=0, so the block is in IDLE.

in_ready SHALL read 1 in the first cycle after rst_n=1, provided clr=0.

REQ-020 Reset asserted mid-pulse or mid-latch SHALL abandon the operation without a final out_valid strobe.

REQ-021 Reset SHALL take priority over clr and over accept.

Verification
REQ-022 SEL_W=2, OUT_N=4, mode=1, en=1, in_valid=1 with sel=0,1,2,3 on consecutive cycles -> dout=0001, 0010, 0100, 1000 on consecutive cycles; out_valid=1 each cycle; in_ready stays 1.

REQ-023 SEL_W=2, OUT_N=3, mode=1, en=1, sel=3 -> dout=000 and err=1; after several idle cycles err is still 1; then clr=1 for one cycle -> err=0.

REQ-024 STRETCH=3, mode=0, sel=2, en=1 -> dout=0100 for exactly 3 cycles, then 0000; in_ready=0 for those 3 cycles; a request held with in_valid=1 is accepted in the cycle after the pulse.

REQ-025 mode=1, sel=1 accepted (dout=0010), then en=0 accept -> dout=0000 with out_valid=1 and err unchanged.

REQ-026 STRETCH=4 pulse started, rst_n=0 on the 2nd stretch cycle -> next edge gives dout=0, err=0, counter=0; after release in_ready=1.

REQ-027 Latch dout=1000 held, clr=1 with in_valid=1 in the same cycle -> in_ready=0, the request is not accepted, dout=0000 and out_valid stays 0.

Source files
------------

// File: rtl/decoder_nx_reg_if.sv
// decoder_nx_reg_if: request/response bundle for decoder_nx_reg.
// The master drives requests and clear; the slave returns ready and the decode.
interface decoder_nx_reg_if #(
    parameter int SEL_W = 2,
    parameter int OUT_N = 4
);
    logic             en;
    logic [SEL_W-1:0] sel;
    logic             mode;
    logic             in_valid;
    logic             in_ready;
    logic             clr;
    logic [OUT_N-1:0] dout;
    logic             out_valid;
    logic             err;

    modport master (
        output en, sel, mode, in_valid, clr,
        input  in_ready, dout, out_valid, err
    );

    modport slave (
        input  en, sel, mode, in_valid, clr,
        output in_ready, dout, out_valid, err
    );
endinterface

// File: rtl/decoder_nx_reg.sv
// decoder_nx_reg: registered N-way line decoder with latch or
// stretched-pulse outputs and a sticky out-of-range error.
module decoder_nx_reg #(
    parameter int SEL_W   = 2,
    parameter int OUT_N   = 4,
    parameter int STRETCH = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    decoder_nx_reg_if.slave bus
);
    typedef enum logic {IDLE, STRETCHING} state_t;

    state_t           state, state_nx;
    logic [7:0]       cnt, cnt_nx;
    logic [OUT_N-1:0] dout_q, dout_nx, dec;
    logic             ov_q, ov_nx;
    logic             err_q, err_nx;
    logic             busy, accept, in_rng;

    if (OUT_N < 2 || OUT_N > 2**SEL_W) begin : g_bad_out_n
        $error("decoder_nx_reg: OUT_N out of range");
    end
    if (STRETCH < 1 || STRETCH > 255) begin : g_bad_stretch
        $error("decoder_nx_reg: STRETCH out of range");
    end

    assign busy         = (state == STRETCHING);
    assign bus.in_ready = ~bus.clr & ~busy;
    assign accept       = bus.in_valid & bus.in_ready;
    assign in_rng       = 32'(bus.sel) < OUT_N;

    always_comb begin
        dec = '0;
        for (int i = 0; i < OUT_N; i++) begin
            dec[i] = (32'(bus.sel) == i);
        end
    end

    // clr, accept and a running stretch are mutually exclusive here
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        dout_nx  = dout_q;
        ov_nx    = 1'b0;
        err_nx   = err_q;
        unique case (1'b1)
            bus.clr: begin
                state_nx = IDLE;
                cnt_nx   = '0;
                dout_nx  = '0;
                err_nx   = 1'b0;
            end
            accept: begin
                ov_nx   = 1'b1;
                dout_nx = bus.en ? dec : '0;
                if (bus.en && !in_rng) begin
                    err_nx = 1'b1;
                end
                if (!bus.mode) begin
                    state_nx = STRETCHING;
                    cnt_nx   = 8'(STRETCH);
                end
            end
            busy && !bus.clr: begin
                cnt_nx = cnt - 8'd1;
                if (cnt == 8'd1) begin
                    state_nx = IDLE;
                    dout_nx  = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            dout_q <= '0;
            ov_q   <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            dout_q <= dout_nx;
            ov_q   <= ov_nx;
            err_q  <= err_nx;
        end
    end

    assign bus.dout      = dout_q;
    assign bus.out_valid = ov_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_decoder_nx_reg.sv
// tb_decoder_nx_reg: scoreboard bench for two decoder_nx_reg builds
// (4 lines / stretch 3, and 3 lines / stretch 1).
module tb_decoder_nx_reg;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    decoder_nx_reg_if #(.SEL_W(2), .OUT_N(4)) ia ();
    decoder_nx_reg_if #(.SEL_W(2), .OUT_N(3)) ib ();

    decoder_nx_reg #(.SEL_W(2), .OUT_N(4), .STRETCH(3)) u_a (
        .clk(clk), .rst_n(rst_n), .bus(ia)
    );
    decoder_nx_reg #(.SEL_W(2), .OUT_N(3), .STRETCH(1)) u_b (
        .clk(clk), .rst_n(rst_n), .bus(ib)
    );

    typedef struct packed {
        logic [3:0] dout;
        logic       ov;
        logic       err;
    } exp_t;

    exp_t q[$];
    exp_t m[2];
    int   left[2];
    int   n_chk = 0;
    int   n_pass = 0;

    function automatic int n_out(input int d);
        return (d == 0) ? 4 : 3;
    endfunction

    function automatic int str(input int d);
        return (d == 0) ? 3 : 1;
    endfunction

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic drv(input int d, input logic v, input logic e,
                       input logic [1:0] s, input logic md,
                       input logic c);
        if (d == 0) begin
            ia.in_valid = v; ia.en = e; ia.sel = s;
            ia.mode = md; ia.clr = c;
        end else begin
            ib.in_valid = v; ib.en = e; ib.sel = s;
            ib.mode = md; ib.clr = c;
        end
    endtask

    // one clock: predict at negedge, compare #1 after the posedge
    task automatic cyc();
        logic v, e, md, c, rdy, acc;
        logic [1:0] s;
        exp_t x;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            if (d == 0) begin
                v = ia.in_valid; e = ia.en; s = ia.sel;
                md = ia.mode; c = ia.clr; rdy = ia.in_ready;
            end else begin
                v = ib.in_valid; e = ib.en; s = ib.sel;
                md = ib.mode; c = ib.clr; rdy = ib.in_ready;
            end
            chk($sformatf("in_ready%0d", d), {7'd0, rdy},
                {7'd0, (!c && left[d] == 0)});
            acc = v && !c && left[d] == 0;
            m[d].ov = 1'b0;
            if (!rst_n) begin
                m[d] = '0;
                left[d] = 0;
            end else if (c) begin
                m[d].dout = '0;
                m[d].err = 1'b0;
                left[d] = 0;
            end else if (acc) begin
                m[d].ov = 1'b1;
                if (!e) m[d].dout = '0;
                else if (int'(s) >= n_out(d)) begin
                    m[d].dout = '0;
                    m[d].err = 1'b1;
                end else m[d].dout = 4'd1 << s;
                left[d] = md ? 0 : str(d);
            end else if (left[d] > 0) begin
                left[d]--;
                if (left[d] == 0) m[d].dout = '0;
            end
            q.push_back(m[d]);
        end
        @(posedge clk);
        #1;
        x = q.pop_front();
        chk("dout0", {4'd0, ia.dout}, {4'd0, x.dout});
        chk("out_valid0", {7'd0, ia.out_valid}, {7'd0, x.ov});
        chk("err0", {7'd0, ia.err}, {7'd0, x.err});
        x = q.pop_front();
        chk("dout1", {5'd0, ib.dout}, {4'd0, x.dout});
        chk("out_valid1", {7'd0, ib.out_valid}, {7'd0, x.ov});
        chk("err1", {7'd0, ib.err}, {7'd0, x.err});
    endtask

    task automatic idle(input int n);
        drv(0, 0, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        m[0] = '0; m[1] = '0;
        left[0] = 0; left[1] = 0;
        drv(0, 0, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        idle(2);
        rst_n = 1'b1;
        idle(1);

        // latch mode, back-to-back selects
        for (int i = 0; i < 4; i++) begin
            drv(0, 1, 1, 2'(i), 1, 0);
            cyc();
        end
        idle(2);

        // latch then disabled accept
        drv(0, 1, 1, 2'd1, 1, 0); cyc();
        drv(0, 1, 0, 2'd3, 1, 0); cyc();
        idle(1);

        // stretched pulse with a held follow-on request
        drv(0, 1, 1, 2'd2, 0, 0); cyc();
        drv(0, 1, 1, 2'd3, 1, 0);
        for (int i = 0; i < 4; i++) cyc();
        idle(2);

        // disabled pulse still blocks
        drv(0, 1, 0, 2'd1, 0, 0); cyc();
        drv(0, 1, 1, 2'd0, 1, 0);
        for (int i = 0; i < 4; i++) cyc();
        idle(1);

        // reset during the second stretch cycle
        drv(0, 1, 1, 2'd3, 0, 0); cyc();
        idle(1);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        idle(2);

        // clr against a held latch and a pending request
        drv(0, 1, 1, 2'd3, 1, 0); cyc();
        drv(0, 1, 1, 2'd1, 1, 1); cyc();
        idle(2);

        // out-of-range select on the 3-line build
        drv(1, 1, 1, 2'd3, 1, 0); cyc();
        idle(4);
        drv(1, 1, 1, 2'd3, 0, 1); cyc();
        idle(1);

        // stretch-1 pulses with a held request
        drv(1, 1, 1, 2'd2, 0, 0);
        for (int i = 0; i < 4; i++) cyc();
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
